// File: rtl/data_mem_ctrl.sv
// Memory-stage load/store unit: issues one request/acknowledge data-bus access per
// load or store, applies byte lanes and extension, and stalls the pipeline until done.

package data_mem_pkg;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned OPER_W  = 6;

    typedef enum logic [OPER_W-1:0] {
        OP_NOP,
        OP_ADD,
        OP_LB,
        OP_LBU,
        OP_LH,
        OP_LHU,
        OP_LW,
        OP_LWPC,
        OP_SB,
        OP_SH,
        OP_SW
    } Oper_t;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } bus_cmd_t;
endpackage

module data_mem_ctrl
    import data_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  Oper_t       oper,
    input  logic [31:0] mem_oper_addr,
    input  logic [31:0] mem_oper_data,
    input  logic        wreg_write_i,
    input  logic [4:0]  wreg_addr_i,
    input  logic [31:0] wreg_data_i,
    input  logic        flush,
    input  logic        stall_hold,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wreg_write_o,
    output logic [4:0]  wreg_addr_o,
    output logic [31:0] wreg_data_o,
    output logic        stallreq,
    output logic        adel_o,
    output logic        ades_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic                is_load;
    logic                is_store;
    logic                is_half;
    logic                is_word;
    logic                is_mem;
    logic                misalign;
    logic                start;
    logic [BE_W-1:0]     be_c;
    logic [XLEN-1:0]     wdata_c;

    bus_cmd_t            cmd_q;
    Oper_t               oper_q;
    logic [1:0]          off_q;
    logic                load_q;
    logic                wreg_write_q;
    logic [RADDR_W-1:0]  wreg_addr_q;
    logic [XLEN-1:0]     rdata_q;

    // Little-endian lane selection with sign/zero extension of a returned bus word.
    function automatic logic [XLEN-1:0] load_extract(input Oper_t op, input logic [1:0] off,
                                                     input logic [XLEN-1:0] w);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Operation decode, alignment check and bus field formation.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (oper)
            OP_LB, OP_LBU:  is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load = 1'b1;
                is_half = 1'b1;
            end
            OP_LW, OP_LWPC: begin
                is_load = 1'b1;
                is_word = 1'b1;
            end
            OP_SB:          is_store = 1'b1;
            OP_SH: begin
                is_store = 1'b1;
                is_half  = 1'b1;
            end
            OP_SW: begin
                is_store = 1'b1;
                is_word  = 1'b1;
            end
            default: ;
        endcase
        is_mem   = is_load | is_store;
        misalign = (is_half & mem_oper_addr[0]) | (is_word & (mem_oper_addr[1:0] != 2'b00));
        start    = is_mem & ~misalign & ~flush;

        if (is_word)
            be_c = 4'b1111;
        else if (is_half)
            be_c = mem_oper_addr[1] ? 4'b1100 : 4'b0011;
        else
            be_c = 4'b0001 << mem_oper_addr[1:0];

        if (!is_store)
            wdata_c = '0;
        else if (is_word)
            wdata_c = mem_oper_data;
        else if (is_half)
            wdata_c = {2{mem_oper_data[15:0]}};
        else
            wdata_c = {4{mem_oper_data[7:0]}};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_REQ;
            S_REQ: begin
                if (bus_ack)
                    state_next = flush ? S_IDLE : S_DONE;
                else if (flush)
                    state_next = S_DRAIN;
            end
            S_DONE:  if (!stall_hold || flush) state_next = S_IDLE;
            S_DRAIN: if (bus_ack) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command latched on issue; load result captured on ack of a live request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= '0;
            oper_q       <= OP_NOP;
            off_q        <= 2'b00;
            load_q       <= 1'b0;
            wreg_write_q <= 1'b0;
            wreg_addr_q  <= '0;
            rdata_q      <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                cmd_q.we     <= is_store;
                cmd_q.be     <= be_c;
                cmd_q.addr   <= {mem_oper_addr[31:2], 2'b00};
                cmd_q.wdata  <= wdata_c;
                oper_q       <= oper;
                off_q        <= mem_oper_addr[1:0];
                load_q       <= is_load;
                wreg_write_q <= wreg_write_i;
                wreg_addr_q  <= wreg_addr_i;
            end
            if (state == S_REQ && bus_ack)
                rdata_q <= load_extract(oper_q, off_q, bus_rdata);
        end
    end

    // Outputs; everything reads as zero while reset is applied.
    always_comb begin
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_be       = '0;
        bus_addr     = '0;
        bus_wdata    = '0;
        wreg_write_o = 1'b0;
        wreg_addr_o  = '0;
        wreg_data_o  = '0;
        stallreq     = 1'b0;
        adel_o       = 1'b0;
        ades_o       = 1'b0;
        if (!rst) begin
            unique case (state)
                S_IDLE: begin
                    if (!is_mem) begin
                        wreg_write_o = wreg_write_i;
                        wreg_addr_o  = wreg_addr_i;
                        wreg_data_o  = wreg_data_i;
                    end else begin
                        adel_o   = is_load & misalign;
                        ades_o   = is_store & misalign;
                        stallreq = start;
                        if (misalign) begin
                            wreg_addr_o = wreg_addr_i;
                            wreg_data_o = wreg_data_i;
                        end
                    end
                end
                S_REQ, S_DRAIN: begin
                    bus_req   = 1'b1;
                    bus_we    = cmd_q.we;
                    bus_be    = cmd_q.be;
                    bus_addr  = cmd_q.addr;
                    bus_wdata = cmd_q.wdata;
                    stallreq  = 1'b1;
                end
                S_DONE: begin
                    wreg_write_o = load_q & wreg_write_q & ~flush;
                    wreg_addr_o  = wreg_addr_q;
                    wreg_data_o  = load_q ? rdata_q : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized accesses
// compared against an arithmetic model of lanes, extension and handshake timing.

module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    Oper_t       oper;
    logic [31:0] mem_oper_addr;
    logic [31:0] mem_oper_data;
    logic        wreg_write_i;
    logic [4:0]  wreg_addr_i;
    logic [31:0] wreg_data_i;
    logic        flush;
    logic        stall_hold;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        wreg_write_o;
    logic [4:0]  wreg_addr_o;
    logic [31:0] wreg_data_o;
    logic        stallreq;
    logic        adel_o;
    logic        ades_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .oper          (oper),
        .mem_oper_addr (mem_oper_addr),
        .mem_oper_data (mem_oper_data),
        .wreg_write_i  (wreg_write_i),
        .wreg_addr_i   (wreg_addr_i),
        .wreg_data_i   (wreg_data_i),
        .flush         (flush),
        .stall_hold    (stall_hold),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_be        (bus_be),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .wreg_write_o  (wreg_write_o),
        .wreg_addr_o   (wreg_addr_o),
        .wreg_data_o   (wreg_data_o),
        .stallreq      (stallreq),
        .adel_o        (adel_o),
        .ades_o        (ades_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for non-memory operations.
    function automatic int unsigned op_size(input Oper_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB:  return 1;
            OP_LH, OP_LHU, OP_SH:  return 2;
            OP_LW, OP_LWPC, OP_SW: return 4;
            default:               return 0;
        endcase
    endfunction

    function automatic bit op_load(input Oper_t op);
        return (op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU ||
                op == OP_LW || op == OP_LWPC);
    endfunction

    function automatic bit op_signed(input Oper_t op);
        return (op == OP_LB || op == OP_LH);
    endfunction

    function automatic logic [31:0] m_be(input Oper_t op, input logic [31:0] a);
        int unsigned lanes;
        lanes = ((32'd1 << op_size(op)) - 1) << (a % 4);
        return 32'(lanes);
    endfunction

    function automatic logic [31:0] m_wdata(input Oper_t op, input logic [31:0] d);
        case (op_size(op))
            1:       return (d % 256) * 32'h0101_0101;
            2:       return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input Oper_t op, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint m;
        longint v;
        m = longint'(1) << (8 * op_size(op));
        v = longint'(rd >> (8 * (a % 4))) % m;
        if (op_signed(op) && v >= m / 2)
            v = v - m;
        return 32'(v);
    endfunction

    // One complete access: issue, wait states, DONE with optional hold, then a pass-through op.
    task automatic run_mem(input Oper_t op, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int wait_n, input int hold_n);
        bit          ld;
        bit          mis;
        int          stall_cnt;
        logic [4:0]  wa;
        logic [31:0] exp_ld;
        ld     = op_load(op);
        mis    = (a % op_size(op)) != 0;
        wa     = 5'($urandom);
        exp_ld = m_load(op, a, rd);

        @(negedge clk);
        oper = op; mem_oper_addr = a; mem_oper_data = d;
        wreg_write_i = 1'b1; wreg_addr_i = wa; wreg_data_i = $urandom;
        flush = 1'b0; stall_hold = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        chk("adel", 32'(adel_o), 32'(ld & mis));
        chk("ades", 32'(ades_o), 32'(!ld & mis));
        chk("issue_req", 32'(bus_req), 32'd0);
        chk("issue_wr", 32'(wreg_write_o), 32'd0);
        if (mis) begin
            chk("mis_stall", 32'(stallreq), 32'd0);
            @(negedge clk);
            oper = OP_NOP; wreg_write_i = 1'b0;
            #1;
            chk("mis_noreq", 32'(bus_req), 32'd0);
            chk("mis_nostall", 32'(stallreq), 32'd0);
            return;
        end
        stall_cnt = int'(stallreq);

        for (int k = 0; k <= wait_n; k++) begin
            @(negedge clk);
            bus_ack   = (k == wait_n);
            bus_rdata = (k == wait_n) ? rd : $urandom;
            #1;
            stall_cnt += int'(stallreq);
            chk("req", 32'(bus_req), 32'd1);
            chk("we", 32'(bus_we), 32'(!ld));
            chk("be", 32'(bus_be), m_be(op, a));
            chk("addr", bus_addr, a & 32'hFFFF_FFFC);
            if (!ld)
                chk("wdata", bus_wdata, m_wdata(op, d));
        end

        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom; stall_hold = (hold_n > 0);
        #1;
        chk("stall_cycles", 32'(stall_cnt), 32'(wait_n + 2));
        chk("done_req", 32'(bus_req), 32'd0);
        chk("done_stall", 32'(stallreq), 32'd0);
        chk("done_wr", 32'(wreg_write_o), 32'(ld));
        if (ld) begin
            chk("done_data", wreg_data_o, exp_ld);
            chk("done_waddr", 32'(wreg_addr_o), 32'(wa));
        end

        for (int j = 1; j <= hold_n; j++) begin
            @(negedge clk);
            stall_hold = (j < hold_n);
            #1;
            chk("hold_req", 32'(bus_req), 32'd0);
            chk("hold_wr", 32'(wreg_write_o), 32'(ld));
            if (ld)
                chk("hold_data", wreg_data_o, exp_ld);
        end

        @(negedge clk);
        stall_hold = 1'b0; oper = OP_ADD;
        wreg_write_i = 1'($urandom); wreg_addr_i = 5'($urandom); wreg_data_i = $urandom;
        #1;
        chk("gap_req", 32'(bus_req), 32'd0);
        chk("gap_stall", 32'(stallreq), 32'd0);
        chk("pass_wr", 32'(wreg_write_o), 32'(wreg_write_i));
        chk("pass_waddr", 32'(wreg_addr_o), 32'(wreg_addr_i));
        chk("pass_wdata", wreg_data_o, wreg_data_i);
    endtask

    Oper_t mem_ops [9] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWPC, OP_SB, OP_SH, OP_SW};

    initial begin
        rst = 1'b1; oper = OP_LW; mem_oper_addr = 32'h8000_0010; mem_oper_data = $urandom;
        wreg_write_i = 1'b1; wreg_addr_i = 5'd3; wreg_data_i = $urandom;
        flush = 1'b0; stall_hold = 1'b0; bus_ack = 1'b0; bus_rdata = '0;

        // Reset state with a live op on the inputs.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_stall", 32'(stallreq), 32'd0);
        chk("rst_wr", 32'(wreg_write_o), 32'd0);
        chk("rst_wdata", wreg_data_o, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        @(negedge clk);
        rst = 1'b0; oper = OP_NOP; wreg_write_i = 1'b0;

        // Directed scenarios.
        run_mem(OP_LW,  32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 2, 0);
        run_mem(OP_LB,  32'h8000_0013, 32'h0,         32'h80FF_0000, 0, 0);
        run_mem(OP_LBU, 32'h8000_0013, 32'h0,         32'h80FF_0000, 1, 0);
        run_mem(OP_SH,  32'h8000_0002, 32'h1234_ABCD, 32'h0,         1, 0);
        run_mem(OP_LW,  32'h8000_0006, 32'h0,         32'h0,         0, 0);
        run_mem(OP_SW,  32'h8000_0001, 32'h5555_AAAA, 32'h0,         0, 0);
        run_mem(OP_LH,  32'h8000_0102, 32'h0,         32'h8001_7FFF, 0, 2);

        // Flush in REQ without ack: request persists through DRAIN until ack.
        @(negedge clk);
        oper = OP_LW; mem_oper_addr = 32'h8000_0020; wreg_write_i = 1'b1;
        #1; chk("fl_issue_stall", 32'(stallreq), 32'd1);
        @(negedge clk); flush = 1'b1;
        #1; chk("fl_req", 32'(bus_req), 32'd1);
        @(negedge clk); flush = 1'b0;
        #1; chk("drain_req", 32'(bus_req), 32'd1);
        chk("drain_stall", 32'(stallreq), 32'd1);
        chk("drain_addr", bus_addr, 32'h8000_0020);
        @(negedge clk); bus_ack = 1'b1;
        #1; chk("drain_req_ack", 32'(bus_req), 32'd1);
        @(negedge clk); bus_ack = 1'b0; oper = OP_NOP; wreg_write_i = 1'b0;
        #1; chk("drain_end_req", 32'(bus_req), 32'd0);
        chk("drain_end_wr", 32'(wreg_write_o), 32'd0);
        chk("drain_end_stall", 32'(stallreq), 32'd0);

        // Flush coinciding with ack: straight back to IDLE, no write-back.
        @(negedge clk);
        oper = OP_LH; mem_oper_addr = 32'h8000_0030; wreg_write_i = 1'b1;
        @(negedge clk); flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        #1; chk("flack_req", 32'(bus_req), 32'd1);
        @(negedge clk); flush = 1'b0; bus_ack = 1'b0; oper = OP_NOP; wreg_write_i = 1'b0;
        #1; chk("flack_req_off", 32'(bus_req), 32'd0);
        chk("flack_wr", 32'(wreg_write_o), 32'd0);

        // Flush in IDLE suppresses the request.
        @(negedge clk);
        oper = OP_SW; mem_oper_addr = 32'h8000_0040; flush = 1'b1;
        @(negedge clk); flush = 1'b0; oper = OP_NOP;
        #1; chk("flidle_noreq", 32'(bus_req), 32'd0);

        // Reset in REQ clears everything at the next edge.
        @(negedge clk);
        oper = OP_SW; mem_oper_addr = 32'h8000_0050; mem_oper_data = 32'hCAFE_F00D;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; oper = OP_NOP; wreg_write_i = 1'b0; wreg_addr_i = '0; wreg_data_i = '0;
        #1;
        chk("rstreq_req", 32'(bus_req), 32'd0);
        chk("rstreq_stall", 32'(stallreq), 32'd0);
        chk("rstreq_be", 32'(bus_be), 32'd0);
        chk("rstreq_addr", bus_addr, 32'd0);
        chk("rstreq_wdata", wreg_data_o, 32'd0);

        // Randomized accesses, including misaligned addresses.
        for (int i = 0; i < 60; i++) begin
            run_mem(mem_ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
